// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm siren controller.
package alarm_pkg;

    // Controller states.
    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StGrace   = 3'd2,
        StSound   = 3'd3,
        StLockout = 3'd4
    } siren_state_t;

    localparam int unsigned DefGraceCycles = 10;
    localparam int unsigned DefSoundCycles = 100;
    localparam int unsigned DefToneHalf    = 4;

    // Width of a down-counter able to hold the value n (never below 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave siren divider. Clears while disabled so the tone is 1 on the
// first enabled cycle, then toggles every TONE_HALF cycles.
module tone_gen
    import alarm_pkg::*;
#(
    parameter int unsigned TONE_HALF = DefToneHalf
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tone
);

    localparam int unsigned HW = cnt_width(TONE_HALF);

    logic [HW-1:0] cnt_q, cnt_d;
    logic          tone_q, tone_d;

    // Divider next-state: a zero count means "toggle now and reload".
    always_comb begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (en) begin
            if (cnt_q == '0) begin
                tone_d = ~tone_q;
                cnt_d  = HW'(TONE_HALF - 1);
            end else begin
                tone_d = tone_q;
                cnt_d  = cnt_q - HW'(1);
            end
        end
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tone_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tone_q <= tone_d;
        end
    end

    assign tone = tone_q;

endmodule

// File: rtl/alarm_siren_ctrl.sv
// Siren controller: entry grace period, timed siren, post-timeout lockout
// with strobe, and a saturating trip counter. Disarm always wins.
module alarm_siren_ctrl
    import alarm_pkg::*;
#(
    parameter int unsigned GRACE_CYCLES = DefGraceCycles,
    parameter int unsigned SOUND_CYCLES = DefSoundCycles,
    parameter int unsigned TONE_HALF    = DefToneHalf,
    parameter int unsigned CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             alarm_in,
    input  logic             secure_in,
    input  logic             disarm,
    output logic             siren,
    output logic             strobe,
    output logic             sounding,
    output logic [CNT_W-1:0] trip_count
);

    localparam int unsigned GW = cnt_width(GRACE_CYCLES);
    localparam int unsigned SW = cnt_width(SOUND_CYCLES);

    siren_state_t     state_q, state_d;
    logic [GW-1:0]    grace_q, grace_d;
    logic [SW-1:0]    sound_q, sound_d;
    logic [CNT_W-1:0] trip_q, trip_d;
    logic             strobe_q, strobe_d;
    logic             sounding_q, sounding_d;

    // Next-state and counter logic.
    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        sound_d = sound_q;
        trip_d  = trip_q;
        if (disarm) begin
            state_d = StIdle;
            grace_d = '0;
            sound_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (secure_in) state_d = StArmed;
                end
                StArmed: begin
                    // Upstream drops secure when it raises alarm, so alarm wins.
                    if (alarm_in) begin
                        state_d = StGrace;
                        grace_d = GW'(GRACE_CYCLES - 1);
                    end else if (!secure_in) begin
                        state_d = StIdle;
                    end
                end
                StGrace: begin
                    if (grace_q == '0) begin
                        state_d = StSound;
                        sound_d = SW'(SOUND_CYCLES - 1);
                        if (trip_q != '1) trip_d = trip_q + CNT_W'(1);
                    end else begin
                        grace_d = grace_q - GW'(1);
                    end
                end
                StSound: begin
                    if (sound_q == '0) state_d = StLockout;
                    else               sound_d = sound_q - SW'(1);
                end
                StLockout: begin
                    state_d = StLockout;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Moore outputs decoded from the next state so they register with it.
    always_comb begin
        strobe_d   = (state_d == StSound) || (state_d == StLockout);
        sounding_d = (state_d == StSound);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            grace_q    <= '0;
            sound_q    <= '0;
            trip_q     <= '0;
            strobe_q   <= 1'b0;
            sounding_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            grace_q    <= grace_d;
            sound_q    <= sound_d;
            trip_q     <= trip_d;
            strobe_q   <= strobe_d;
            sounding_q <= sounding_d;
        end
    end

    // Enabled from the next state so the tone phase lines up with SOUND entry.
    tone_gen #(
        .TONE_HALF (TONE_HALF)
    ) u_tone_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (sounding_d),
        .tone  (siren)
    );

    assign strobe     = strobe_q;
    assign sounding   = sounding_q;
    assign trip_count = trip_q;

endmodule

// File: tb/tb_alarm_siren_ctrl.sv
// Self-checking bench for alarm_siren_ctrl with default parameters.
module tb_alarm_siren_ctrl;

    localparam int unsigned CW = 8;
    localparam int unsigned OW = CW + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          alarm_in = 1'b0;
    logic          secure_in = 1'b0;
    logic          disarm = 1'b0;
    logic          siren;
    logic          strobe;
    logic          sounding;
    logic [CW-1:0] trip_count;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic          sec;
        logic          al;
        logic          dis;
        logic [OW-1:0] exp;
    } vec_t;

    vec_t vecs[24];

    alarm_siren_ctrl #(
        .GRACE_CYCLES (10),
        .SOUND_CYCLES (100),
        .TONE_HALF    (4),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alarm_in   (alarm_in),
        .secure_in  (secure_in),
        .disarm     (disarm),
        .siren      (siren),
        .strobe     (strobe),
        .sounding   (sounding),
        .trip_count (trip_count)
    );

    always #5 clk = ~clk;

    wire [OW-1:0] outs = {siren, strobe, sounding, trip_count};

    function automatic logic [OW-1:0] pk(input bit s, input bit st, input bit so, input int t);
        return {s, st, so, CW'(t)};
    endfunction

    task automatic check(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got siren/strobe/sounding/trip=%b/%b/%b/%0d required %b/%b/%b/%0d",
                      name, act[OW-1], act[OW-2], act[OW-3], act[CW-1:0],
                      exp[OW-1], exp[OW-2], exp[OW-3], exp[CW-1:0]);
    endtask

    // Drive inputs, let one rising edge pass, return 1 time unit after it.
    task automatic cyc(input logic s, input logic a, input logic d);
        secure_in = s;
        alarm_in  = a;
        disarm    = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_trip;

        // Main trip sequence: arm, 10 grace cycles, then SOUND with 1111 0000 tone.
        vecs[0] = '{1'b1, 1'b0, 1'b0, pk(0, 0, 0, 0)};
        vecs[1] = '{1'b0, 1'b1, 1'b0, pk(0, 0, 0, 0)};
        for (int i = 2; i <= 10; i++) vecs[i] = '{1'b0, 1'b0, 1'b0, pk(0, 0, 0, 0)};
        for (int i = 11; i <= 23; i++) begin
            int k;
            k = i - 10;
            vecs[i] = '{1'b0, 1'b0, 1'b0, pk(((k - 1) / 4) % 2 == 0, 1, 1, 1)};
        end

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs, pk(0, 0, 0, 0));
        rst_n = 1'b1;
        cyc(0, 0, 0);
        check("idle_after_reset", outs, pk(0, 0, 0, 0));

        for (int i = 0; i < 24; i++) begin
            cyc(vecs[i].sec, vecs[i].al, vecs[i].dis);
            check($sformatf("vec%0d", i), outs, vecs[i].exp);
        end
        // Rest of SOUND (cycles 14..100), then LOCKOUT.
        for (int k = 14; k <= 100; k++) begin
            cyc(0, 0, 0);
            check($sformatf("sound_cyc%0d", k), outs, pk(((k - 1) / 4) % 2 == 0, 1, 1, 1));
        end
        cyc(0, 0, 0);
        check("lockout_entry", outs, pk(0, 1, 0, 1));
        for (int i = 0; i < 3; i++) begin
            cyc(1, 1, 0);
            check("lockout_ignores_alarm", outs, pk(0, 1, 0, 1));
        end
        repeat (12) cyc(0, 0, 0);
        check("lockout_no_retrip", outs, pk(0, 1, 0, 1));
        cyc(0, 0, 1);
        check("lockout_disarm", outs, pk(0, 0, 0, 1));

        // Disarm on GRACE cycle 5.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        check("grace2_c1", outs, pk(0, 0, 0, 1));
        for (int i = 2; i <= 5; i++) begin
            cyc(0, 0, 0);
            check("grace2_quiet", outs, pk(0, 0, 0, 1));
        end
        cyc(0, 0, 1);
        check("grace_disarm", outs, pk(0, 0, 0, 1));
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0);
            check("after_grace_disarm", outs, pk(0, 0, 0, 1));
        end

        // Held disarm keeps IDLE despite secure; alarm with secure low then stays idle.
        repeat (3) cyc(1, 0, 1);
        cyc(0, 1, 0);
        for (int i = 0; i < 12; i++) begin
            cyc(0, 0, 0);
            check("held_disarm_idle", outs, pk(0, 0, 0, 1));
        end

        // ARMED with secure and alarm both low returns to IDLE.
        cyc(1, 0, 0);
        cyc(0, 0, 0);
        cyc(0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        check("armed_drop_to_idle", outs, pk(0, 0, 0, 1));

        // Alarm with secure low on the same cycle enters GRACE.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (9) cyc(0, 0, 0);
        check("alarm_over_secure_grace", outs, pk(0, 0, 0, 1));
        cyc(0, 0, 0);
        check("alarm_over_secure_sound", outs, pk(1, 1, 1, 2));
        cyc(0, 0, 1);
        check("sound_disarm", outs, pk(0, 0, 0, 2));

        // Trip counter saturation.
        exp_trip = 2;
        for (int i = 0; i < 260; i++) begin
            cyc(1, 0, 0);
            cyc(0, 1, 0);
            repeat (10) cyc(0, 0, 0);
            if (exp_trip < 255) exp_trip++;
            check($sformatf("sat_trip%0d", i), outs, pk(1, 1, 1, exp_trip));
            cyc(0, 0, 1);
        end
        check("sat_final", outs, pk(0, 0, 0, 255));

        // Asynchronous reset mid-SOUND while siren is high.
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 0);
        cyc(0, 0, 0);
        check("pre_reset_sound", outs, pk(1, 1, 1, 255));
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", outs, pk(0, 0, 0, 0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset", outs, pk(0, 0, 0, 0));
        cyc(0, 1, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 0);
        check("post_reset_idle", outs, pk(0, 0, 0, 0));
        cyc(1, 0, 0);
        cyc(0, 1, 0);
        repeat (10) cyc(0, 0, 0);
        check("post_reset_trip", outs, pk(1, 1, 1, 1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alarm_siren_ctrl.md
# alarm_siren_ctrl

Downstream stage of the combinational alarm evaluator: consumes its `alarm` and `secure` outputs and drives the physical warning devices. Adds an entry grace period, a timed siren with a square-wave tone, a post-timeout lockout with a persistent strobe, and a saturating trip counter. Disarm from the keypad path has absolute priority.

## Interface
- `GRACE_CYCLES`, default 10: cycles spent in GRACE before sounding; must be ≥1.
- `SOUND_CYCLES`, default 100: cycles spent in SOUND before LOCKOUT; must be ≥1.
- `TONE_HALF`, default 4: siren half-period in cycles; must be ≥1.
- `CNT_W`, default 8: trip counter width.
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `alarm_in`, input, 1: `alarm` from the alarm evaluator.
- `secure_in`, input, 1: `secure` from the alarm evaluator.
- `disarm`, input, 1: keypad disarm; level, sampled each cycle.
- `siren`, output, 1: audible tone drive.
- `strobe`, output, 1: visual beacon.
- `sounding`, output, 1: high while in SOUND.
- `trip_count`, output, CNT_W: number of GRACE→SOUND transitions, saturating.

## Operation
- States: IDLE, ARMED, GRACE, SOUND, LOCKOUT. Moore outputs; all outputs are registered.
- `disarm`=1 in any state moves to IDLE on the next edge. It overrides every other condition.
- IDLE: if `secure_in`=1, go to ARMED.
- ARMED:
  - If `alarm_in`=1, go to GRACE and load the grace counter with GRACE_CYCLES−1.
  - Else if `secure_in`=0, go to IDLE (upstream disarmed).
  - `alarm_in` takes priority over `secure_in`=0, because the upstream stage drops `secure` whenever it raises `alarm`.
- GRACE:
  - Decrement the counter each cycle.
  - On a cycle with counter=0, go to SOUND, load the sound counter with SOUND_CYCLES−1, and increment `trip_count`.
  - `trip_count` saturates at 2^CNT_W−1.
  - Deasserting `alarm_in` or `secure_in` does not cancel GRACE; only `disarm` does.
- SOUND:
  - Tone divider is enabled. `siren` is 1 on the first SOUND cycle and toggles every TONE_HALF cycles.
  - `strobe`=1 and `sounding`=1.
  - On a cycle with sound counter=0, go to LOCKOUT.
- LOCKOUT:
  - `siren`=0, `strobe`=1, `sounding`=0.
  - Inputs other than `disarm` are ignored, so no re-trip occurs.
- Output values per state:
  - IDLE, ARMED, GRACE: `siren`=0, `strobe`=0, `sounding`=0.
  - SOUND: as listed under SOUND above.
  - LOCKOUT: as listed under LOCKOUT above.
- `disarm` in GRACE leaves `trip_count` unchanged.
- `trip_count` is cleared only by reset.

## Timing
- Reset values: state IDLE, `siren`=0, `strobe`=0, `sounding`=0, `trip_count`=0, all counters 0.
- Latency: one cycle from an input change to the state change; outputs reflect the new state on that same edge.
- GRACE residency is exactly GRACE_CYCLES cycles.
- SOUND residency is exactly SOUND_CYCLES cycles.
- The `trip_count` increment is visible on the first SOUND cycle.
- The tone phase restarts at every SOUND entry. The last SOUND cycle is followed by `siren`=0 regardless of phase.
- Asserting reset mid-SOUND drops `siren` immediately (asynchronously); no partial tone persists.
- A `disarm` pulse of a single cycle is sufficient.
- A `disarm` held high keeps the block in IDLE even with `secure_in`=1.

## Structure
- Package `alarm_pkg` holds:
  - the state enum `siren_state_t`;
  - default constants for GRACE_CYCLES, SOUND_CYCLES and TONE_HALF;
  - a shared counter-width function based on $clog2(N+1).
- Sub-module `tone_gen(TONE_HALF)`: `clk`, `rst_n`, `en`, `tone`.
  - The divider clears when `en`=0, so `tone` starts at 1 on the first enabled cycle.
- The FSM, grace/sound counters and trip counter live in `alarm_siren_ctrl`.

## Test plan
- Reset, then `secure_in`=1 for 1 cycle, then `alarm_in`=1 with `secure_in`=0. Required: ARMED, then exactly 10 GRACE cycles, then `sounding`=1 and `trip_count`=1. `siren` pattern is 1111 0000 1111…
- Trip, then `disarm`=1 on GRACE cycle 5. Required: IDLE on the next edge, `siren` never high, `trip_count` unchanged.
- Trip and let it run. Required: `sounding` high for exactly 100 cycles, then LOCKOUT with `siren`=0 and `strobe`=1. A new `alarm_in` pulse is ignored. `disarm` returns to IDLE with `strobe`=0.
- ARMED with `secure_in`=0 and `alarm_in`=0. Required: IDLE after 1 cycle, no GRACE entry. With `alarm_in`=1 and `secure_in`=0 on the same cycle: GRACE is entered.
- Run 260 trip/disarm-in-SOUND cycles with CNT_W=8. Required: `trip_count` saturates at 255.
- Assert `rst_n`=0 mid-SOUND while `siren`=1. Required: all outputs 0 immediately, without waiting for a clock edge; state is IDLE after release.
